// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller behind a UART receiver: hunts for SYNC, captures a length-prefixed
// payload, verifies its XOR checksum and replays good frames over a valid/ready stream.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 50_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic [7:0] frame_len,
  output logic       busy,
  output logic       err_chk,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int IW    = $clog2(MAX_LEN + 1);
  localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);
  localparam logic [TW-1:0] CNT_ONE   = TW'(1);

  typedef enum logic [2:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    len_q;
  logic [7:0]    chk_q;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] to_cnt;
  logic [7:0]    buf_mem [DEPTH];

  logic in_frame;
  logic timeout_hit;
  logic is_last;
  logic len_load;
  logic pay_wr;
  logic drain_adv;
  logic ev_chk;
  logic ev_len;
  logic ev_timeout;
  logic ev_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_next;
    end
  end

  // A byte arriving on the would-be timeout cycle wins: timeout_hit requires rx_valid low.
  always_comb begin
    state_next  = state;
    len_load    = 1'b0;
    pay_wr      = 1'b0;
    drain_adv   = 1'b0;
    ev_chk      = 1'b0;
    ev_len      = 1'b0;
    ev_timeout  = 1'b0;
    ev_overrun  = 1'b0;
    in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CHK);
    timeout_hit = in_frame && !rx_valid && (to_cnt == TO_LAST);
    is_last     = (8'(rd_idx) == (len_q - 8'd1));

    case (state)
      HUNT: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_next = LEN;
        end
      end
      LEN: begin
        if (rx_valid) begin
          if ((rx_data != 8'd0) && (rx_data <= MAX_LEN_B)) begin
            len_load   = 1'b1;
            state_next = PAYLOAD;
          end else begin
            ev_len     = 1'b1;
            state_next = HUNT;
          end
        end else if (timeout_hit) begin
          ev_timeout = 1'b1;
          state_next = HUNT;
        end
      end
      PAYLOAD: begin
        if (rx_valid) begin
          pay_wr = 1'b1;
          if (8'(wr_idx) == (len_q - 8'd1)) begin
            state_next = CHK;
          end
        end else if (timeout_hit) begin
          ev_timeout = 1'b1;
          state_next = HUNT;
        end
      end
      CHK: begin
        if (rx_valid) begin
          if (rx_data == chk_q) begin
            state_next = DRAIN;
          end else begin
            ev_chk     = 1'b1;
            state_next = HUNT;
          end
        end else if (timeout_hit) begin
          ev_timeout = 1'b1;
          state_next = HUNT;
        end
      end
      DRAIN: begin
        ev_overrun = rx_valid;
        if (m_ready) begin
          drain_adv = 1'b1;
          if (is_last) begin
            state_next = HUNT;
          end
        end
      end
      default: begin
        state_next = HUNT;
      end
    endcase
  end

  always_comb begin
    m_valid   = (state == DRAIN);
    m_last    = m_valid && is_last;
    m_data    = m_valid ? buf_mem[rd_idx[AW-1:0]] : 8'h00;
    busy      = (state != HUNT);
    frame_len = len_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= 8'd0;
      chk_q       <= 8'd0;
      wr_idx      <= '0;
      rd_idx      <= '0;
      to_cnt      <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_chk     <= ev_chk;
      err_len     <= ev_len;
      err_timeout <= ev_timeout;
      err_overrun <= ev_overrun;

      if (len_load) begin
        len_q  <= rx_data;
        chk_q  <= rx_data;
        wr_idx <= '0;
      end else if (pay_wr) begin
        chk_q  <= chk_q ^ rx_data;
        wr_idx <= wr_idx + IDX_ONE;
      end

      if (state != DRAIN) begin
        rd_idx <= '0;
      end else if (drain_adv) begin
        rd_idx <= rd_idx + IDX_ONE;
      end

      if (!in_frame || rx_valid || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + CNT_ONE;
      end
    end
  end

  // Payload storage carries no reset; contents are only read after a full capture.
  always_ff @(posedge clk) begin
    if (pay_wr) begin
      buf_mem[wr_idx[AW-1:0]] <= rx_data;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: directed frames push expected bytes,
// a forked monitor pops and compares on every downstream handshake.
module tb_uart_rx_frame_ctrl;

  localparam int TO = 40;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic [7:0] frame_len;
  logic       busy;
  logic       err_chk;
  logic       err_len;
  logic       err_timeout;
  logic       err_overrun;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [7:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_item;

  int compared = 0;
  int mismatched = 0;
  int chk_seen = 0;
  int len_seen = 0;
  int to_seen = 0;
  int ovr_seen = 0;
  int base_chk, base_len, base_to, base_ovr;

  logic       bp_mode = 1'b0;
  logic       ready_level = 1'b1;
  logic       stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  uart_rx_frame_ctrl #(
    .MAX_LEN(16),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready),
    .frame_len(frame_len),
    .busy(busy),
    .err_chk(err_chk),
    .err_len(err_len),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always begin
    @(posedge clk);
    #1;
    m_ready = bp_mode ? ~m_ready : ready_level;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic l, input logic [7:0] n);
    exp_q.push_back('{data: d, last: l, len: n});
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic snap_errors();
    base_chk = chk_seen;
    base_len = len_seen;
    base_to  = to_seen;
    base_ovr = ovr_seen;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (err_chk) chk_seen++;
      if (err_len) len_seen++;
      if (err_timeout) to_seen++;
      if (err_overrun) ovr_seen++;
      if (stall_prev && !rst) begin
        checkOutput("stall_hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_byte: got %0h required no output", m_data);
        end else begin
          exp_item = exp_q.pop_front();
          checkOutput("m_data", 32'(m_data), 32'(exp_item.data));
          checkOutput("m_last", 32'(m_last), 32'(exp_item.last));
          checkOutput("frame_len", 32'(frame_len), 32'(exp_item.len));
        end
      end
      stall_prev = m_valid && !m_ready && !rst;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    fork
      monitor();
    join_none
    idle(3);
    checkOutput("reset_outputs",
      32'({m_data, m_valid, m_last, frame_len, busy, err_chk, err_len, err_timeout, err_overrun}), 32'd0);
    rst = 1'b0;
    idle(2);

    $display("[TB] good frame");
    snap_errors();
    expect_byte(8'h11, 1'b0, 8'd3);
    expect_byte(8'h22, 1'b0, 8'd3);
    expect_byte(8'h33, 1'b1, 8'd3);
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h03);
    checkOutput("drain_start", 32'({m_valid, m_data}), 32'({1'b1, 8'h11}));
    idle(3);
    checkOutput("drain_end", 32'({m_valid, busy}), 32'd0);
    wait_drain();
    checkOutput("good_no_errors", 32'((chk_seen - base_chk) + (len_seen - base_len) + (to_seen - base_to) + (ovr_seen - base_ovr)), 32'd0);

    $display("[TB] backpressure");
    bp_mode = 1'b1;
    expect_byte(8'h11, 1'b0, 8'd3);
    expect_byte(8'h22, 1'b0, 8'd3);
    expect_byte(8'h33, 1'b1, 8'd3);
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h03);
    wait_drain();
    idle(1);
    bp_mode = 1'b0;
    checkOutput("bp_hunt", 32'(busy), 32'd0);
    idle(2);

    $display("[TB] bad checksum");
    snap_errors();
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    applyStimulus(8'h31);
    checkOutput("err_chk_pulse", 32'(err_chk), 32'd1);
    idle(2);
    checkOutput("err_chk_count", 32'(chk_seen - base_chk), 32'd1);
    checkOutput("chk_busy", 32'(busy), 32'd0);

    $display("[TB] length errors");
    snap_errors();
    applyStimulus(8'hA5);
    applyStimulus(8'h00);
    applyStimulus(8'hA5);
    applyStimulus(8'h11);
    idle(2);
    checkOutput("err_len_count", 32'(len_seen - base_len), 32'd2);
    expect_byte(8'h7E, 1'b1, 8'd1);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h7E);
    applyStimulus(8'h7F);
    wait_drain();

    $display("[TB] timeout");
    snap_errors();
    applyStimulus(8'h00);
    applyStimulus(8'hFF);
    applyStimulus(8'h5A);
    checkOutput("garbage_ignored", 32'(busy), 32'd0);
    applyStimulus(8'hA5);
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    idle(TO - 1);
    checkOutput("timeout_early", 32'({err_timeout, busy}), 32'({1'b0, 1'b1}));
    idle(1);
    checkOutput("timeout_edge", 32'({err_timeout, busy}), 32'({1'b1, 1'b0}));
    idle(2);
    checkOutput("timeout_count", 32'(to_seen - base_to), 32'd1);

    $display("[TB] overrun");
    snap_errors();
    ready_level = 1'b0;
    expect_byte(8'h42, 1'b1, 8'd1);
    applyStimulus(8'hA5);
    applyStimulus(8'h01);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    idle(2);
    applyStimulus(8'h55);
    checkOutput("overrun_pulse", 32'(err_overrun), 32'd1);
    checkOutput("overrun_drain", 32'({busy, m_valid, m_last, m_data}), 32'({1'b1, 1'b1, 1'b1, 8'h42}));
    ready_level = 1'b1;
    wait_drain();
    checkOutput("overrun_count", 32'(ovr_seen - base_ovr), 32'd1);

    $display("[TB] reset mid-payload");
    snap_errors();
    applyStimulus(8'hA5);
    applyStimulus(8'h03);
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    rst = 1'b1;
    idle(1);
    checkOutput("midframe_reset",
      32'({m_data, m_valid, m_last, frame_len, busy, err_chk, err_len, err_timeout, err_overrun}), 32'd0);
    rst = 1'b0;
    idle(3);
    checkOutput("reset_no_errors", 32'((chk_seen - base_chk) + (len_seen - base_len) + (to_seen - base_to) + (ovr_seen - base_ovr)), 32'd0);
    checkOutput("final_queue", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
